// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encoding, FSM states and
// the size-to-byte-count helper.
package lsu_pkg;

    localparam logic [1:0] SzByte  = 2'd0;
    localparam logic [1:0] SzHalf  = 2'd1;
    localparam logic [1:0] SzWord  = 2'd2;
    localparam logic [1:0] SzDword = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StWr,
        StErr
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for a big-endian 64-bit RAM word: load extraction with
// sign/zero extension, and sub-dword store merge over the previously read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [63:0] rdata_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] load_o,
    output logic [63:0] merge_o
);

    logic sext;

    // The addressed byte always sits in the top lane, so its MSB is rdata_i[63].
    assign sext = signed_i & rdata_i[63];

    always_comb begin
        load_o  = rdata_i;
        merge_o = wdata_i;
        unique case (size_i)
            SzByte: begin
                load_o  = {{56{sext}}, rdata_i[63:56]};
                merge_o = {wdata_i[7:0], rdata_i[55:0]};
            end
            SzHalf: begin
                load_o  = {{48{sext}}, rdata_i[63:48]};
                merge_o = {wdata_i[15:0], rdata_i[47:0]};
            end
            SzWord: begin
                load_o  = {{32{sext}}, rdata_i[63:32]};
                merge_o = {wdata_i[31:0], rdata_i[31:0]};
            end
            SzDword: begin
                load_o  = rdata_i;
                merge_o = wdata_i;
            end
            default: begin
                load_o  = rdata_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between execute and a byte-addressed big-endian 64-bit RAM.
// Optional misalignment trap is enabled with the LSU_MISALIGN_TRAP_EN macro.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [63:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_cs_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic [63:0] mem_rdata_i
);

    lsu_state_e  state_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [63:0] wdata_q;
    logic        mem_cs_q;
    logic        mem_we_q;
    logic [63:0] mem_addr_q;
    logic [63:0] mem_wdata_q;
    logic        rsp_valid_q;
    logic [63:0] rsp_rdata_q;
    logic [63:0] load_data;
    logic [63:0] merge_data;

    lsu_align u_align (
        .size_i   (size_q),
        .signed_i (signed_q),
        .rdata_i  (mem_rdata_i),
        .wdata_i  (wdata_q),
        .load_o   (load_data),
        .merge_o  (merge_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    logic rsp_err_q;

    assign misalign  = (req_addr_i[3:0] & (size_bytes(req_size_i) - 4'd1)) != 4'd0;
    assign rsp_err_o = rsp_err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            size_q      <= SzByte;
            signed_q    <= 1'b0;
            wdata_q     <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            rsp_err_q   <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        we_q       <= req_we_i;
                        size_q     <= req_size_i;
                        signed_q   <= req_signed_i;
                        wdata_q    <= req_wdata_i;
                        mem_addr_q <= req_addr_i;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misalign) begin
                            state_q <= StErr;
                        end else
`endif
                        if (req_we_i && (req_size_i == SzDword)) begin
                            state_q     <= StWr;
                            mem_cs_q    <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= req_wdata_i;
                        end else begin
                            state_q  <= StRd;
                            mem_cs_q <= 1'b1;
                            mem_we_q <= 1'b0;
                        end
                    end
                end
                StRd: begin
                    mem_cs_q <= 1'b0;
                    state_q  <= StCap;
                end
                StCap: begin
                    if (we_q) begin
                        mem_wdata_q <= merge_data;
                        mem_cs_q    <= 1'b1;
                        mem_we_q    <= 1'b1;
                        state_q     <= StWr;
                    end else begin
                        rsp_rdata_q <= load_data;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                StWr: begin
                    mem_cs_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    rsp_rdata_q <= '0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StIdle;
                end
`ifdef LSU_MISALIGN_TRAP_EN
                StErr: begin
                    rsp_rdata_q <= '0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    state_q     <= StIdle;
                end
`endif
                default: begin
                    mem_cs_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign mem_cs_o    = mem_cs_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a behavioural 64-byte big-endian RAM plus a
// byte-array reference model, directed plan steps, random traffic and reset abort.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_cs;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_size_i   (req_size),
        .req_signed_i (req_signed),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .mem_cs_o     (mem_cs),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: 64 bytes, wraps modulo 64, 8-byte big-endian access at addr.
    logic [7:0]  ram [64];
    logic        bd_we;
    logic [5:0]  bd_addr;
    logic [63:0] bd_data;

    always_ff @(posedge clk) begin
        if (bd_we) begin
            for (int i = 0; i < 8; i++) ram[bd_addr + 6'(i)] <= bd_data[8*(7-i) +: 8];
        end else if (mem_cs) begin
            if (mem_we) begin
                for (int i = 0; i < 8; i++) ram[mem_addr[5:0] + 6'(i)] <= mem_wdata[8*(7-i) +: 8];
            end else begin
                for (int i = 0; i < 8; i++) mem_rdata[8*(7-i) +: 8] <= ram[mem_addr[5:0] + 6'(i)];
            end
        end
    end

    // Reference model: what memory should hold, byte by byte.
    logic [7:0] ref_mem [64];
    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_load(input logic [63:0] addr, input int n,
                                               input logic sg);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[addr[5:0] + 6'(i)]);
        if (sg && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        return v;
    endfunction

    task automatic model_store(input logic [63:0] addr, input int n, input logic [63:0] wd);
        for (int i = 0; i < n; i++) ref_mem[addr[5:0] + 6'(i)] = 8'(wd >> (8*(n-1-i)));
    endtask

    task automatic backdoor(input logic [5:0] a, input logic [63:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
        for (int i = 0; i < 8; i++) ref_mem[a + 6'(i)] = d[8*(7-i) +: 8];
    endtask

    task automatic compare_image(input string tag);
        logic [63:0] got, exp;
        for (int d = 0; d < 8; d++) begin
            got = '0; exp = '0;
            for (int i = 0; i < 8; i++) begin
                got = (got << 8) | 64'(ram[d*8+i]);
                exp = (exp << 8) | 64'(ref_mem[d*8+i]);
            end
            check($sformatf("%s dword%0d", tag, d), got, exp);
        end
    endtask

    // Issue one request from a negedge; returns at the negedge of the response cycle.
    task automatic run_req(input string tag, input logic we, input logic [1:0] sz,
                           input logic sg, input logic [63:0] addr, input logic [63:0] wd,
                           output logic [63:0] rd_obs);
        int n, lat, cs_cnt, we_cnt, exp_lat, exp_cs, exp_we;
        logic err_exp, err_obs;
        logic [63:0] exp_rd;
        n = 1 << sz;
`ifdef LSU_MISALIGN_TRAP_EN
        err_exp = (addr % 64'(n)) != 64'd0;
`else
        err_exp = 1'b0;
`endif
        exp_rd = '0;
        if (err_exp) begin
            exp_lat = 2; exp_cs = 0; exp_we = 0;
        end else if (!we) begin
            exp_lat = 3; exp_cs = 1; exp_we = 0; exp_rd = model_load(addr, n, sg);
        end else if (n == 8) begin
            exp_lat = 2; exp_cs = 1; exp_we = 1;
        end else begin
            exp_lat = 4; exp_cs = 2; exp_we = 1;
        end
        check({tag, " ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; cs_cnt = 0; we_cnt = 0; err_obs = 1'b0; rd_obs = '0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (mem_cs) cs_cnt++;
            if (mem_we) we_cnt++;
            if (rsp_valid) begin
                lat = k; rd_obs = rsp_rdata; err_obs = rsp_err;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " rdata"}, rd_obs, exp_rd);
        check({tag, " err"}, 64'(err_obs), 64'(err_exp));
        check({tag, " cs_cycles"}, 64'(cs_cnt), 64'(exp_cs));
        check({tag, " we_cycles"}, 64'(we_cnt), 64'(exp_we));
        if (we && !err_exp) model_store(addr, n, wd);
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] wd;
        n_cmp = 0; n_bad = 0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        rst_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_signed = 1'b0;
        req_addr = 64'h10; req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;

        // Fill memory during reset; the held req_valid must be ignored.
        for (int d = 0; d < 8; d++) backdoor(6'(d*8), {$urandom, $urandom});
        backdoor(6'h00, 64'h0123_4567_89AB_CDEF);
        backdoor(6'h08, 64'hFEDC_BA98_7654_3210);
        @(negedge clk);
        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_rdata", rsp_rdata, 64'd0);
        check("reset rsp_err", 64'(rsp_err), 64'd0);
        check("reset mem_cs", 64'(mem_cs), 64'd0);
        check("reset mem_we", 64'(mem_we), 64'd0);
        check("reset mem_addr", mem_addr, 64'd0);
        check("reset mem_wdata", mem_wdata, 64'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        compare_image("preload");

        run_req("ldb_s_0", 1'b0, 2'd0, 1'b1, 64'h0, 64'h0, rd);
        check("ldb_s_0 const", rd, 64'h0000_0000_0000_0001);
        run_req("ldh_s_8", 1'b0, 2'd1, 1'b1, 64'h8, 64'h0, rd);
        check("ldh_s_8 const", rd, 64'hFFFF_FFFF_FFFF_FEDC);
        run_req("ldh_u_8", 1'b0, 2'd1, 1'b0, 64'h8, 64'h0, rd);
        check("ldh_u_8 const", rd, 64'h0000_0000_0000_FEDC);
        run_req("stw_0", 1'b1, 2'd2, 1'b0, 64'h0, 64'h1234_5678_AABB_CCDD, rd);
        run_req("ldd_0", 1'b0, 2'd3, 1'b0, 64'h0, 64'h0, rd);
        check("ldd_0 const", rd, 64'hAABB_CCDD_89AB_CDEF);
        run_req("std_4", 1'b1, 2'd3, 1'b0, 64'h4, 64'h1122_3344_5566_7788, rd);
        run_req("ldd_4", 1'b0, 2'd3, 1'b0, 64'h4, 64'h0, rd);
`ifndef LSU_MISALIGN_TRAP_EN
        check("ldd_4 const", rd, 64'h1122_3344_5566_7788);
`endif
        run_req("ldw_2", 1'b0, 2'd2, 1'b0, 64'h2, 64'h0, rd);
`ifndef LSU_MISALIGN_TRAP_EN
        check("ldw_2 const", rd, 64'h0000_0000_CCDD_1122);
`endif
        compare_image("directed");

        for (int t = 0; t < 60; t++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            run_req($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), a, {$urandom, $urandom}, rd);
        end
        compare_image("random");

        // Abort a dword store while WR is on the bus, before the RAM edge.
        wd = {$urandom, $urandom};
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_signed = 1'b0;
        req_addr = 64'h10; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort mem_we", 64'(mem_we), 64'd0);
        check("abort mem_cs", 64'(mem_cs), 64'd0);
        check("abort rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort hold rsp_valid", 64'(rsp_valid), 64'd0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post-abort rsp_valid", 64'(rsp_valid), 64'd0);
        end
        check("post-abort req_ready", 64'(req_ready), 64'd1);
        compare_image("abort");
        run_req("ldd_10_after_abort", 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, rd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
